ff_seq_checker: RTL and testbench

Self-checking stimulus sequencer for a single-bit registered DUT such as a one-flop cell. On `start` it plays a fixed bit pattern into the DUT's `d` input, one bit per clock. It compares the DUT's `q` output against a latency-delayed copy of the driven value and reports mismatch count, first failing step, and pass/fail. It replaces hand-written per-state stimulus blocks in synthesizable test wrappers, so the same wrapper runs in RTL simulation, post-synthesis simulation and on the board.

---
 rtl/ff_seq_checker_if.sv | 11 +
 rtl/ff_seq_checker.sv | 106 ++++++++++
 tb/tb_ff_seq_checker.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ff_seq_checker_if.sv
// ff_seq_checker_if: run control, results and DUT-side stimulus/response of ff_seq_checker
interface ff_seq_checker_if #(
  parameter int CNT_W = 8,
  parameter int IDX_W = 8
);
  logic start, dut_q, dut_d, busy, done, pass;
  logic [CNT_W-1:0] err_cnt;
  logic [IDX_W-1:0] first_err_idx;
  modport slave(input start, dut_q, output dut_d, busy, done, pass, err_cnt, first_err_idx);
  modport master(output start, dut_q, input dut_d, busy, done, pass, err_cnt, first_err_idx);
endinterface

// File: rtl/ff_seq_checker.sv
// ff_seq_checker: plays PATTERN into a single-bit DUT and checks its output after LAT clocks
module ff_seq_checker #(
  parameter int PAT_LEN = 9,
  parameter logic [PAT_LEN-1:0] PATTERN = 9'b000100110,
  parameter int LAT = 1,
  parameter int CNT_W = 8,
  parameter int IDX_W = 8
) (
  input logic clk,
  input logic rstn,
  ff_seq_checker_if.slave io
);
  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, REPORT} state_t;
  state_t state_q, state_d;
  logic dut_d_q, dut_d_d, dv_q, dv_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [IDX_W-1:0] step_q, step_d, first_err_idx_q, first_err_idx_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [LAT-1:0] val_q, val_d, vld_q, vld_d;
  logic [LAT-1:0][IDX_W-1:0] idx_q, idx_d;
  logic mis, last;
  always_comb begin
    // stage 0 tags the bit currently on dut_d with the step that produced it
    val_d[0] = dut_d_q;
    vld_d[0] = dv_q;
    idx_d[0] = step_q - IDX_W'(1);
    for (int k = 1; k < LAT; k++) begin
      val_d[k] = val_q[k-1];
      vld_d[k] = vld_q[k-1];
      idx_d[k] = idx_q[k-1];
    end
    mis = vld_q[LAT-1] && (io.dut_q != val_q[LAT-1]);
    last = vld_q[LAT-1] && (idx_q[LAT-1] == IDX_W'(PAT_LEN - 1));
    err_cnt_d = (mis && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    first_err_idx_d = (mis && first_err_idx_q == '1) ? idx_q[LAT-1] : first_err_idx_q;
    state_d = state_q;
    dut_d_d = 1'b0;
    dv_d = 1'b0;
    step_d = step_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    case (state_q)
      IDLE: if (io.start) begin
        state_d = DRIVE;
        dut_d_d = PATTERN[0];
        dv_d = 1'b1;
        step_d = IDX_W'(1);
        busy_d = 1'b1;
        err_cnt_d = '0;
        first_err_idx_d = '1;
        pass_d = 1'b0;
      end
      DRIVE: if (step_q == IDX_W'(PAT_LEN)) state_d = DRAIN;
      else begin
        dut_d_d = |(PATTERN & (PAT_LEN'(1) << step_q));
        dv_d = 1'b1;
        step_d = step_q + IDX_W'(1);
      end
      DRAIN: if (last) begin
        state_d = REPORT;
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = err_cnt_d == '0;
      end
      default: begin
        state_d = IDLE;
        step_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      dut_d_q <= 1'b0;
      dv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_cnt_q <= '0;
      first_err_idx_q <= '1;
      step_q <= '0;
      val_q <= '0;
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      dut_d_q <= dut_d_d;
      dv_q <= dv_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_cnt_q <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      step_q <= step_d;
      val_q <= val_d;
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end
  assign io.dut_d = dut_d_q;
  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.pass = pass_q;
  assign io.err_cnt = err_cnt_q;
  assign io.first_err_idx = first_err_idx_q;
endmodule

// File: tb/tb_ff_seq_checker.sv
// tb_ff_seq_checker: two checkers (LAT=1/CNT_W=8 and LAT=2/CNT_W=2) against behavioural DUT models
module tb_ff_seq_checker;
  localparam int NC = 4096;
  typedef struct {int err; int fe; int d;} exp_t;
  logic clk = 0, rstn = 0, start = 0;
  logic [8:0] pat = 9'b000100110;
  logic [7:0] sh0 = '0, sh1 = '0;
  int cyc = 0, total = 0, bad = 0;
  bit mon_en = 0;
  int mode[2], dep[2], next_ok[2];
  bit flip[NC];
  bit expd[2][NC], expb[2][NC], expdn[2][NC], expp[2][NC];
  exp_t sb0[$], sb1[$];
  ff_seq_checker_if #(.CNT_W(8), .IDX_W(8)) ioa();
  ff_seq_checker_if #(.CNT_W(2), .IDX_W(8)) iob();
  ff_seq_checker ua(.clk(clk), .rstn(rstn), .io(ioa));
  ff_seq_checker #(.LAT(2), .CNT_W(2)) ub(.clk(clk), .rstn(rstn), .io(iob));
  always #5 clk = ~clk;
  // DUT modes: 0 ideal n-flop, 1 stuck at 0, 2 inverting, 3 flop with random output flips
  function automatic logic dq(int m, logic v, bit f);
    return m == 1 ? 1'b0 : m == 2 ? ~v : m == 3 ? v ^ f : v;
  endfunction
  assign ioa.start = start;
  assign iob.start = start;
  assign ioa.dut_q = dq(mode[0], sh0[dep[0]-1], flip[(cyc+1)%NC]);
  assign iob.dut_q = dq(mode[1], sh1[dep[1]-1], flip[(cyc+1)%NC]);
  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
    sh0 <= {sh0[6:0], ioa.dut_d};
    sh1 <= {sh1[6:0], iob.dut_d};
  end
  task automatic reset_model(int u, int e);
    for (int c = e; c < NC; c++) begin
      expd[u][c] = 0; expb[u][c] = 0; expdn[u][c] = 0; expp[u][c] = 0;
    end
    if (u == 0) while (sb0.size() > 0 && sb0[$].d >= e) void'(sb0.pop_back());
    else while (sb1.size() > 0 && sb1[$].d >= e) void'(sb1.pop_back());
    next_ok[u] = e + 1;
  endtask
  // a run accepted at edge t0: d during cycle t0+i is pat[i]; an n-flop DUT shows at edge E
  // the d of cycle E-n-1; step i is checked at edge t0+i+lat+1; done in cycle t0+9+lat
  task automatic run_model(int u, int t0);
    int lat, cap, err, fe, j, dd;
    logic v, q;
    exp_t x;
    lat = u + 1; cap = u ? 3 : 255; err = 0; fe = 255; dd = t0 + 9 + lat;
    for (int i = 0; i < 9; i++) begin
      j = i + lat - dep[u];
      v = (j >= 0 && j < 9) ? pat[j] : 1'b0;
      q = dq(mode[u], v, flip[(t0 + i + lat + 1) % NC]);
      if (q != pat[i]) begin
        if (err < cap) err++;
        if (fe == 255) fe = i;
      end
    end
    for (int c = t0; c < NC; c++) begin
      expd[u][c] = c < t0 + 9 ? pat[c-t0] : 1'b0;
      expb[u][c] = c < dd;
      expdn[u][c] = c == dd;
      expp[u][c] = c >= dd && err == 0;
    end
    x.err = err; x.fe = fe; x.d = dd;
    if (u == 0) sb0.push_back(x); else sb1.push_back(x);
    next_ok[u] = dd + 2;
  endtask
  initial begin
    int e;
    forever begin
      @(posedge clk);
      e = cyc + 1;
      for (int u = 0; u < 2; u++)
        if (!rstn) reset_model(u, e);
        else if (start && e >= next_ok[u]) run_model(u, e);
    end
  end
  task automatic chk(string nm, int u, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", nm, u, cyc, act, exp);
    end
  endtask
  task automatic mon(int u, logic dd, logic b, logic dn, logic ps, logic [7:0] ec, logic [7:0] fe);
    exp_t x;
    chk("dut_d", u, 32'(dd), 32'(expd[u][cyc]));
    chk("busy", u, 32'(b), 32'(expb[u][cyc]));
    chk("done", u, 32'(dn), 32'(expdn[u][cyc]));
    chk("pass", u, 32'(ps), 32'(expp[u][cyc]));
    if (expb[u][cyc] && !expb[u][cyc-1]) begin
      chk("err_clr", u, 32'(ec), 0);
      chk("fe_clr", u, 32'(fe), 255);
    end
    if (expdn[u][cyc]) begin
      if (u == 0) x = sb0.pop_front(); else x = sb1.pop_front();
      chk("err_cnt", u, 32'(ec), x.err);
      chk("first_err_idx", u, 32'(fe), x.fe);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (mon_en && cyc > 0 && cyc < NC) begin
      mon(0, ioa.dut_d, ioa.busy, ioa.done, ioa.pass, ioa.err_cnt, ioa.first_err_idx);
      mon(1, iob.dut_d, iob.busy, iob.done, iob.pass, {6'b0, iob.err_cnt}, iob.first_err_idx);
    end
  end
  task automatic chk_rst();
    chk("rst_err", 0, 32'(ioa.err_cnt), 0);
    chk("rst_fe", 0, 32'(ioa.first_err_idx), 255);
    chk("rst_err", 1, 32'(iob.err_cnt), 0);
    chk("rst_fe", 1, 32'(iob.first_err_idx), 255);
  endtask
  task automatic run(int ma, int mb, int db);
    mode[0] = ma; mode[1] = mb; dep[1] = db;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (16) @(negedge clk);
  endtask
  initial begin
    for (int c = 0; c < NC; c++) flip[c] = 1'($urandom_range(0, 1));
    mode[0] = 0; mode[1] = 0; dep[0] = 1; dep[1] = 2;
    repeat (3) @(negedge clk);
    mon_en = 1;
    chk_rst();
    rstn = 1;
    @(negedge clk);
    run(0, 0, 2);
    run(1, 1, 2);
    run(2, 2, 2);
    run(0, 0, 1);
    run(3, 3, 2);
    start = 1;
    repeat (30) @(negedge clk);
    start = 0;
    repeat (16) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rstn = 0;
    @(negedge clk);
    chk_rst();
    rstn = 1;
    repeat (3) @(negedge clk);
    run(0, 0, 2);
    repeat (15) begin
      mode[0] = $urandom_range(0, 3);
      mode[1] = $urandom_range(0, 3);
      dep[1] = $urandom_range(1, 2);
      repeat (40) begin
        start = $urandom_range(0, 2) == 0;
        rstn = $urandom_range(0, 50) != 0;
        @(negedge clk);
      end
      start = 0;
      rstn = 1;
      repeat (16) @(negedge clk);
    end
    chk("sb_empty", 0, sb0.size(), 0);
    chk("sb_empty", 1, sb1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
